// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one strobe/ack request at a time,
// and buffers returned words with their PCs in an in-order queue for decode.
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] o_imem_addr,
  output logic        o_imem_stb,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_ready,
  output logic        o_misaligned
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {FETCH, HOLD, TRAP} state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [31:0]     q_instr [QDEPTH];
  logic [31:0]     q_pc    [QDEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            pop;

  // Strobe depends only on state, so i_ready never reaches the memory port.
  assign o_imem_addr = pc;
  assign o_imem_stb  = (state == FETCH);
  assign o_valid     = (count != '0);
  assign o_instr     = q_instr[rd_ptr];
  assign o_pc        = q_pc[rd_ptr];

  assign push = (state == FETCH) && i_imem_ack && !i_redirect;
  assign pop  = o_valid && i_ready;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  // Redirect outranks everything except reset; it flushes the queue and drops any ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= FETCH;
      pc           <= PC_RESET;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      o_misaligned <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (i_redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      pc     <= i_redirect_pc;
      if (i_redirect_pc[1:0] == 2'b00) begin
        state        <= FETCH;
        o_misaligned <= 1'b0;
      end else begin
        state        <= TRAP;
        o_misaligned <= 1'b1;
      end
    end else begin
      if (push) begin
        q_instr[wr_ptr] <= i_imem_data;
        q_pc[wr_ptr]    <= pc;
        wr_ptr          <= wr_ptr + PW'(1);
        pc              <= pc + 32'd4;
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      case (state)
        FETCH:   if (count_next == CW'(QDEPTH)) state <= HOLD;
        HOLD:    if (count_next <  CW'(QDEPTH)) state <= FETCH;
        default: state <= TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected {pc, instr}
// pairs; a negedge monitor pops and compares every accepted handshake.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] o_imem_addr;
  logic        o_imem_stb;
  logic        i_imem_ack;
  logic [31:0] i_imem_data;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_ready;
  logic        o_misaligned;

  int          checks   = 0;
  int          failures = 0;
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic        force_ack = 1'b0;
  logic [63:0] exp_q [$];

  fetch_unit #(.PC_RESET(32'h0000_0000), .QDEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_imem_addr  (o_imem_addr),
    .o_imem_stb   (o_imem_stb),
    .i_imem_ack   (i_imem_ack),
    .i_imem_data  (i_imem_data),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .o_valid      (o_valid),
    .o_instr      (o_instr),
    .o_pc         (o_pc),
    .i_ready      (i_ready),
    .o_misaligned (o_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0010_0113;
      default: return {16'hC0DE, addr[15:0]};
    endcase
  endfunction

  // Memory acks after ack_delay strobe cycles; force_ack injects a stray ack.
  always_comb begin
    i_imem_ack  = force_ack || (o_imem_stb && (wait_cnt >= ack_delay));
    i_imem_data = force_ack ? 32'hDEAD_BEEF : mem_word(o_imem_addr);
  end

  always @(posedge clk) begin
    if (!rst_n)
      wait_cnt <= 0;
    else if (o_imem_stb && !i_imem_ack)
      wait_cnt <= wait_cnt + 1;
    else
      wait_cnt <= 0;
  end

  always @(negedge clk) begin
    if (rst_n && o_valid && i_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_delivery got pc=%h instr=%h, required none", o_pc, o_instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({o_pc, o_instr} !== e) begin
          failures++;
          $display("[TB] FAIL delivery got pc=%h instr=%h, required pc=%h instr=%h",
                   o_pc, o_instr, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic applyStimulus(input logic rstn, input logic rdy, input logic redir,
                               input logic [31:0] redir_pc);
    @(posedge clk);
    #1;
    rst_n         = rstn;
    i_ready       = rdy;
    i_redirect    = redir;
    i_redirect_pc = redir_pc;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic expectWord(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  task automatic checkDrained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_drained got %0d pending, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic resetDut(input int delay);
    ack_delay = delay;
    force_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("rst_valid", 32'(o_valid), 32'h0);
    checkOutput("rst_pc", o_pc, 32'h0);
    checkOutput("rst_instr", o_instr, 32'h0);
    checkOutput("rst_misaligned", 32'(o_misaligned), 32'h0);
    checkOutput("rst_addr", o_imem_addr, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; i_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;

    // Streaming with a same-cycle-ack memory: no bubbles.
    resetDut(0);
    expectWord(32'h0, 32'h0050_0093);
    expectWord(32'h4, 32'h0010_0113);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("c0_stb", 32'(o_imem_stb), 32'h1);
    checkOutput("c0_valid", 32'(o_valid), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("c1_valid", 32'(o_valid), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("c2_pc", o_pc, 32'h4);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkDrained("stream");

    // Backpressure: queue fills, strobe drops, head held stable.
    resetDut(0);
    expectWord(32'h0, 32'h0050_0093);
    expectWord(32'h4, 32'h0010_0113);
    expectWord(32'h8, 32'hC0DE_0008);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      if (c >= 2) begin
        checkOutput("bp_stb_low", 32'(o_imem_stb), 32'h0);
        checkOutput("bp_instr_hold", o_instr, 32'h0050_0093);
      end
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      if (c == 1) checkOutput("bp_stb_resume", 32'(o_imem_stb), 32'h1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkDrained("backpressure");

    // Ack delayed by three cycles: address and strobe held across the wait.
    resetDut(3);
    expectWord(32'h0, 32'h0050_0093);
    expectWord(32'h4, 32'h0010_0113);
    expectWord(32'h8, 32'hC0DE_0008);
    for (int c = 0; c < 13; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      if (c <= 3) begin
        checkOutput("dly_addr_hold", o_imem_addr, 32'h0);
        checkOutput("dly_stb_hold", 32'(o_imem_stb), 32'h1);
      end
      if (c == 5) checkOutput("dly_addr_next", o_imem_addr, 32'h4);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkDrained("delayed");

    // Redirect colliding with the ack for 0x8: that word must never appear.
    resetDut(0);
    expectWord(32'h0, 32'h0050_0093);
    expectWord(32'h4, 32'h0010_0113);
    expectWord(32'h40, 32'hC0DE_0040);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
    @(negedge clk);
    checkOutput("redir_collide_addr", o_imem_addr, 32'h8);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("redir_flush_valid", 32'(o_valid), 32'h0);
    checkOutput("redir_addr", o_imem_addr, 32'h40);
    checkOutput("redir_stb", 32'(o_imem_stb), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("redir_first_pc", o_pc, 32'h40);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkDrained("redirect");

    // Misaligned redirect traps until an aligned redirect recovers.
    resetDut(0);
    expectWord(32'h80, 32'hC0DE_0080);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h42);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("trap_misaligned", 32'(o_misaligned), 32'h1);
      checkOutput("trap_stb", 32'(o_imem_stb), 32'h0);
      checkOutput("trap_valid", 32'(o_valid), 32'h0);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h80);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("recover_misaligned", 32'(o_misaligned), 32'h0);
    checkOutput("recover_addr", o_imem_addr, 32'h80);
    checkOutput("recover_stb", 32'(o_imem_stb), 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkDrained("trap");

    // One-cycle reset during an outstanding delayed request, with a stray ack.
    resetDut(3);
    expectWord(32'h0, 32'h0050_0093);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      if (c == 4) checkOutput("midrst_buffered", 32'(o_valid), 32'h1);
      if (c == 5) checkOutput("midrst_pending_addr", o_imem_addr, 32'h4);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    force_ack = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    force_ack = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid", 32'(o_valid), 32'h0);
    checkOutput("midrst_pc", o_pc, 32'h0);
    checkOutput("midrst_instr", o_instr, 32'h0);
    checkOutput("midrst_addr", o_imem_addr, 32'h0);
    checkOutput("midrst_stb", 32'(o_imem_stb), 32'h1);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      if (c == 1) checkOutput("midrst_no_stray", 32'(o_valid), 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkDrained("midreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
